// File: rtl/alu_uart_sequencer.sv
// Frame controller: collects A, B, opcode bytes from the UART RX, lets the ALU settle,
// then sends the result through the UART TX. Optional inter-byte timeout: SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
    parameter int SIZEDATA       = 8,
    parameter int SIZEOP         = 6,
    parameter int ALU_LAT        = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_alu_datoa,
    output logic [SIZEDATA-1:0] o_alu_datob,
    output logic [SIZEOP-1:0]   o_alu_opcode,
    output logic                o_tx_start,
    output logic [SIZEDATA-1:0] o_tx_data,
    output logic                o_busy,
    output logic                o_drop,
    output logic                o_frame_err
);

    typedef enum logic [2:0] {
        GET_A, GET_B, GET_OP, EXEC, TX_START, TX_WAIT
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    state_t     state, state_next;
    logic [3:0] lat_cnt;
    logic       busy, busy_next;
    logic       load_a, load_b, load_op, capture;
    logic       timeout_hit;

    assign busy      = (state == EXEC) || (state == TX_START) || (state == TX_WAIT);
    assign busy_next = (state_next == EXEC) || (state_next == TX_START) ||
                       (state_next == TX_WAIT);

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    // Only the mid-frame states are guarded; an accepted byte restarts the window.
    assign waiting     = (state == GET_B) || (state == GET_OP);
    assign timeout_hit = waiting && !i_rx_done && (to_cnt == TO_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            to_cnt <= '0;
        end else if (!waiting || i_rx_done || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        case (state)
            GET_A: begin
                if (i_rx_done) begin
                    load_a     = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    load_b     = 1'b1;
                    state_next = GET_OP;
                end else if (timeout_hit) begin
                    state_next = GET_A;
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    load_op    = 1'b1;
                    state_next = EXEC;
                end else if (timeout_hit) begin
                    state_next = GET_A;
                end
            end
            EXEC: begin
                if (lat_cnt == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START: state_next = TX_WAIT;
            TX_WAIT: begin
                if (i_tx_done) begin
                    state_next = GET_A;
                end
            end
            default: state_next = GET_A;
        endcase
    end

    // Result is sampled ALU_LAT edges after the opcode register updates.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lat_cnt <= '0;
        end else if (load_op) begin
            lat_cnt <= '0;
        end else if (state == EXEC) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_alu_datoa  <= '0;
            o_alu_datob  <= '0;
            o_alu_opcode <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_drop       <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            if (load_a) begin
                o_alu_datoa <= i_rx_data;
            end
            if (load_b) begin
                o_alu_datob <= i_rx_data;
            end
            if (load_op) begin
                o_alu_opcode <= i_rx_data[SIZEOP-1:0];
            end
            if (capture) begin
                o_tx_data <= i_alu_result;
            end
            o_tx_start  <= (state_next == TX_START);
            o_busy      <= busy_next;
            o_drop      <= i_rx_done && busy;
            o_frame_err <= timeout_hit;
        end
    end

endmodule
